// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART word loader.
//   state_t       : loader FSM states (COLLECT / WRITE / DONE)
//   CHECKSUM_W    : width of the running byte-sum output
//   MAX_DATA_W    : widest word the default-terminator helper supports
//   default_term(): all-ones pattern of a given width (default terminator)
package uart_loader_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WRITE   = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int unsigned CHECKSUM_W = 16;
   localparam int unsigned MAX_DATA_W = 256;

   // All-ones in the low w bits; callers truncate to their word width.
   function automatic logic [MAX_DATA_W-1:0] default_term(input int unsigned w);
      logic [MAX_DATA_W-1:0] t;
      t = '0;
      for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
         if (i < w) t[i] = 1'b1;
      end
      return t;
   endfunction

endpackage

// File: rtl/uart_loader_assembler.sv
// Byte-to-word assembler: places byte k of a word at bits [8k+7:8k].
//   clk, resetn      : clock, async active-low reset
//   i_byte_valid     : accept i_byte this cycle
//   i_byte           : received byte
//   i_clear          : drop the partial word, byte index back to 0
//   o_word_c         : stored bytes merged with the byte being accepted
//   o_word_valid_c   : the byte being accepted completes a word
//   o_busy           : a partial word is held (byte index != 0)
module uart_loader_assembler
   import uart_loader_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_byte_valid,
   input  logic [7:0]        i_byte,
   input  logic              i_clear,
   output logic [DATA_W-1:0] o_word_c,
   output logic              o_word_valid_c,
   output logic              o_busy
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_word;
   logic              w_last;

   assign w_last = (r_idx == LAST_IDX);

   // Merge the incoming byte into its lane so the completed word is
   // available in the same cycle its final byte is sampled.
   always_comb begin
      o_word_c = r_word;
      for (int unsigned k = 0; k < NB; k++) begin
         if (r_idx == IDX_W'(k)) o_word_c[8*k +: 8] = i_byte;
      end
   end

   assign o_word_valid_c = i_byte_valid & ~i_clear & w_last;
   assign o_busy         = (r_idx != '0);

   // Byte index and word storage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_clear) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_byte_valid) begin
         r_word <= o_word_c;
         r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/uart_word_loader.sv
// UART-to-instruction-memory loader: assembles bytes LSB-first into
// DATA_W-bit words and writes them to consecutive addresses from BASE_ADDR,
// stopping on TERM_WORD or when MAX_WORDS is exceeded.
// Optional feature macro: UART_LOADER_CHECKSUM_EN (16-bit byte sum of
// written words; tied to 0 when undefined).
//   clk, resetn           : clock, async active-low reset
//   rx_valid, rx_data     : received byte strobe and data
//   rx_break              : UART BREAK, drops the partial word
//   rearm                 : restart a load from BASE_ADDR
//   mem_we/addr/wdata     : instruction-memory write port
//   word_count            : words written since reset/rearm
//   busy                  : partial word held
//   write_done            : terminator seen or capacity exceeded (sticky)
//   overflow_err          : word arrived beyond MAX_WORDS (sticky)
//   checksum              : running byte sum of written words
module uart_word_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 8,
   parameter int unsigned       BASE_ADDR = 0,
   parameter int unsigned       MAX_WORDS = 2**ADDR_W,
   parameter logic [DATA_W-1:0] TERM_WORD = DATA_W'(default_term(DATA_W))
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic                  rx_break,
   input  logic                  rearm,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [ADDR_W:0]       word_count,
   output logic                  busy,
   output logic                  write_done,
   output logic                  overflow_err,
   output logic [CHECKSUM_W-1:0] checksum
);

   localparam int unsigned NB = DATA_W / 8;
   localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

   state_t            r_state;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [ADDR_W:0]   r_word_count;
   logic              r_write_done;
   logic              r_overflow_err;

   logic              w_live;
   logic              w_byte_valid;
   logic              w_clear;
   logic [DATA_W-1:0] w_word;
   logic              w_word_valid;
   logic              w_busy;
   logic              w_is_term;
   logic              w_full;

   // DONE ignores bytes and breaks; rearm and break both drop the byte.
   assign w_live       = (r_state != DONE);
   assign w_byte_valid = rx_valid & w_live & ~rx_break & ~rearm;
   assign w_clear      = rearm | (rx_break & w_live);

   uart_loader_assembler #(
      .DATA_W (DATA_W)
   ) u_asm (
      .clk            (clk),
      .resetn         (resetn),
      .i_byte_valid   (w_byte_valid),
      .i_byte         (rx_data),
      .i_clear        (w_clear),
      .o_word_c       (w_word),
      .o_word_valid_c (w_word_valid),
      .o_busy         (w_busy)
   );

   assign w_is_term = (w_word == TERM_WORD);
   assign w_full    = (r_word_count == MAX_CNT);

   // Loader FSM. A word completing during WRITE is evaluated exactly as in
   // COLLECT, so back-to-back strobes lose nothing.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state        <= COLLECT;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= BASE;
         r_mem_wdata    <= '0;
         r_word_count   <= '0;
         r_write_done   <= 1'b0;
         r_overflow_err <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         if (rearm) begin
            r_state        <= COLLECT;
            r_word_count   <= '0;
            r_write_done   <= 1'b0;
            r_overflow_err <= 1'b0;
         end else begin
            case (r_state)
               COLLECT, WRITE: begin
                  r_state <= COLLECT;
                  if (w_word_valid) begin
                     if (w_is_term) begin
                        r_state      <= DONE;
                        r_write_done <= 1'b1;
                     end else if (w_full) begin
                        r_state        <= DONE;
                        r_write_done   <= 1'b1;
                        r_overflow_err <= 1'b1;
                     end else begin
                        r_state      <= WRITE;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= BASE + r_word_count[ADDR_W-1:0];
                        r_mem_wdata  <= w_word;
                        r_word_count <= r_word_count + (ADDR_W+1)'(1);
                     end
                  end
               end
               DONE: begin
                  r_state <= DONE;
               end
               default: begin
                  r_state <= COLLECT;
               end
            endcase
         end
      end
   end

   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign word_count   = r_word_count;
   assign busy         = w_busy;
   assign write_done   = r_write_done;
   assign overflow_err = r_overflow_err;

`ifdef UART_LOADER_CHECKSUM_EN
   logic [CHECKSUM_W-1:0] r_checksum;
   logic [CHECKSUM_W-1:0] w_word_sum;
   logic                  w_write_go;

   // Same condition that launches a memory write.
   assign w_write_go = w_word_valid & ~w_is_term & ~w_full;

   always_comb begin
      w_word_sum = '0;
      for (int unsigned k = 0; k < NB; k++) begin
         w_word_sum = w_word_sum + CHECKSUM_W'(w_word[8*k +: 8]);
      end
   end

   // Running sum of written words only; lands together with mem_we.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_checksum <= '0;
      end else if (rearm) begin
         r_checksum <= '0;
      end else if (w_write_go) begin
         r_checksum <= r_checksum + w_word_sum;
      end
   end

   assign checksum = r_checksum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// Testbench for uart_word_loader: two instances (32-bit word / capacity 2,
// and 16-bit word / base 4 / 4-bit address) share one byte stream and are
// compared each cycle against a byte-level reference model.
module tb_uart_word_loader;

   logic        clk;
   logic        resetn;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_break;
   logic        rearm;

   logic        a_mem_we,  b_mem_we;
   logic [7:0]  a_mem_addr;
   logic [3:0]  b_mem_addr;
   logic [31:0] a_mem_wdata;
   logic [15:0] b_mem_wdata;
   logic [8:0]  a_word_count;
   logic [4:0]  b_word_count;
   logic        a_busy, b_busy;
   logic        a_write_done, b_write_done;
   logic        a_overflow_err, b_overflow_err;
   logic [15:0] a_checksum, b_checksum;

   uart_word_loader #(
      .DATA_W (32), .ADDR_W (8), .BASE_ADDR (0), .MAX_WORDS (2)
   ) u_a (
      .clk (clk), .resetn (resetn), .rx_valid (rx_valid), .rx_data (rx_data),
      .rx_break (rx_break), .rearm (rearm), .mem_we (a_mem_we),
      .mem_addr (a_mem_addr), .mem_wdata (a_mem_wdata),
      .word_count (a_word_count), .busy (a_busy), .write_done (a_write_done),
      .overflow_err (a_overflow_err), .checksum (a_checksum)
   );

   uart_word_loader #(
      .DATA_W (16), .ADDR_W (4), .BASE_ADDR (4)
   ) u_b (
      .clk (clk), .resetn (resetn), .rx_valid (rx_valid), .rx_data (rx_data),
      .rx_break (rx_break), .rearm (rearm), .mem_we (b_mem_we),
      .mem_addr (b_mem_addr), .mem_wdata (b_mem_wdata),
      .word_count (b_word_count), .busy (b_busy), .write_done (b_write_done),
      .overflow_err (b_overflow_err), .checksum (b_checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Instance geometry for the model.
   int unsigned p_nb   [2] = '{4, 2};
   int unsigned p_max  [2] = '{2, 16};
   int unsigned p_base [2] = '{0, 4};
   int unsigned p_aw   [2] = '{8, 4};

   // Reference model: bytes held so far and the visible results.
   logic [7:0]      m_bytes [2][4];
   int unsigned     m_n     [2];
   int unsigned     m_count [2];
   bit              m_done  [2];
   bit              m_ovf   [2];
   int unsigned     m_sum   [2];
   bit              m_we    [2];
   int unsigned     m_addr  [2];
   longint unsigned m_wdata [2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else n_pass++;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_n[i] = 0; m_count[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
         m_sum[i] = 0; m_we[i] = 0; m_addr[i] = p_base[i]; m_wdata[i] = 0;
      end
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit brk, input bit ra);
      longint unsigned w, term;
      for (int i = 0; i < 2; i++) begin
         m_we[i] = 0;
         if (ra) begin
            m_n[i] = 0; m_count[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_sum[i] = 0;
         end else if (m_done[i]) begin
            // loader finished: input ignored
         end else if (brk) begin
            m_n[i] = 0;
         end else if (v) begin
            m_bytes[i][m_n[i]] = d;
            m_n[i]++;
            if (m_n[i] == p_nb[i]) begin
               m_n[i] = 0;
               w = 0;
               for (int k = 0; k < int'(p_nb[i]); k++) w += longint'(m_bytes[i][k]) << (8*k);
               term = (64'd1 << (8*p_nb[i])) - 1;
               if (w == term) begin
                  m_done[i] = 1;
               end else if (m_count[i] == p_max[i]) begin
                  m_done[i] = 1; m_ovf[i] = 1;
               end else begin
                  m_we[i]    = 1;
                  m_addr[i]  = (p_base[i] + m_count[i]) % (32'd1 << p_aw[i]);
                  m_wdata[i] = w;
                  m_count[i]++;
                  for (int k = 0; k < int'(p_nb[i]); k++) m_sum[i] += m_bytes[i][k];
                  m_sum[i] = m_sum[i] % 65536;
               end
            end
         end
      end
   endtask

   task automatic check_inst(input int i, input string pfx, input logic we,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [63:0] cnt, input logic bsy, input logic done,
                             input logic ovf, input logic [63:0] cs);
      int unsigned exp_cs;
`ifdef UART_LOADER_CHECKSUM_EN
      exp_cs = m_sum[i];
`else
      exp_cs = 0;
`endif
      chk({pfx, "_mem_we"},   64'(we),   64'(m_we[i]));
      chk({pfx, "_mem_addr"}, addr,      64'(m_addr[i]));
      chk({pfx, "_wdata"},    wdata,     m_wdata[i]);
      chk({pfx, "_count"},    cnt,       64'(m_count[i]));
      chk({pfx, "_busy"},     64'(bsy),  64'(m_n[i] != 0));
      chk({pfx, "_done"},     64'(done), 64'(m_done[i]));
      chk({pfx, "_ovf"},      64'(ovf),  64'(m_ovf[i]));
      chk({pfx, "_checksum"}, cs,        64'(exp_cs));
   endtask

   task automatic check_all();
      check_inst(0, "a", a_mem_we, 64'(a_mem_addr), 64'(a_mem_wdata), 64'(a_word_count),
                 a_busy, a_write_done, a_overflow_err, 64'(a_checksum));
      check_inst(1, "b", b_mem_we, 64'(b_mem_addr), 64'(b_mem_wdata), 64'(b_word_count),
                 b_busy, b_write_done, b_overflow_err, 64'(b_checksum));
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit brk, input bit ra);
      @(negedge clk);
      rx_valid = v; rx_data = d; rx_break = brk; rearm = ra;
      @(posedge clk);
      model_step(v, d, brk, ra);
      #1;
      check_all();
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic do_reset();
      @(negedge clk);
      rx_valid = 0; rx_data = 0; rx_break = 0; rearm = 0;
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0; rx_valid = 0; rx_data = 0; rx_break = 0; rearm = 0;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      resetn = 1'b1;

      // First word and terminator.
      send(8'h13); send(8'h01); send(8'h01); send(8'hFD);
      chk("t1_we",    64'(a_mem_we),    64'd1);
      chk("t1_addr",  64'(a_mem_addr),  64'd0);
      chk("t1_wdata", 64'(a_mem_wdata), 64'hFD010113);
      send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
      chk("t1_done",  64'(a_write_done), 64'd1);
      chk("t1_count", 64'(a_word_count), 64'd1);
      step(0, 0, 0, 0);
      chk("t1_no_we", 64'(a_mem_we), 64'd0);

      // Bytes after DONE are ignored, then rearm.
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("t4_no_we", 64'(a_mem_we), 64'd0);
      step(0, 0, 0, 1);
      chk("t4_rearm_done", 64'(a_write_done), 64'd0);

      // Break discards a partial word.
      send(8'hAA); send(8'hBB); send(8'hCC);
      step(0, 0, 1, 0);
      send(8'h23); send(8'h26); send(8'h81); send(8'h02);
      chk("t2_wdata", 64'(a_mem_wdata), 64'h02812623);
      chk("t2_addr",  64'(a_mem_addr),  64'd0);
      step(0, 0, 0, 0);

      // Capacity exceeded on instance a.
      step(0, 0, 0, 1);
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < 4; k++) send(8'(16*w + k + 1));
      end
      chk("t3_ovf",   64'(a_overflow_err), 64'd1);
      chk("t3_done",  64'(a_write_done),   64'd1);
      chk("t3_count", 64'(a_word_count),   64'd2);

      // Rearm coincident with the final byte: byte dropped, no write.
      step(0, 0, 0, 1);
      send(8'h01); send(8'h02); send(8'h03);
      step(1, 8'h04, 0, 1);
      chk("t5_we",    64'(a_mem_we),     64'd0);
      chk("t5_count", 64'(a_word_count), 64'd0);
      chk("t5_busy",  64'(a_busy),       64'd0);

      // 16-bit instance at base 4, then reset mid-word.
      step(0, 0, 0, 1);
      send(8'h34); send(8'h12);
      chk("t6_wdata", 64'(b_mem_wdata), 64'h1234);
      chk("t6_addr",  64'(b_mem_addr),  64'd4);
      send(8'hFF); send(8'hFF);
      chk("t6_done",  64'(b_write_done), 64'd1);
      send(8'h55); send(8'h66);
      do_reset();

      // Randomized traffic, including back-to-back strobes.
      for (int n = 0; n < 3000; n++) begin
         bit          v, brk, ra;
         logic [7:0]  d;
         v   = ($urandom_range(1, 0) == 1);
         d   = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
         brk = ($urandom_range(39, 0) == 0);
         ra  = ($urandom_range(79, 0) == 0);
         if ($urandom_range(499, 0) == 0) do_reset();
         else step(v, d, brk, ra);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
